// File: rtl/dmem_hs.sv
// Handshaked data memory with configurable read latency, load extension and
// access-fault reporting; one request outstanding at a time.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down the remaining read latency
// RESP  | response held until the consumer accepts it
module dmem_hs #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [31:0]     mem [DEPTH];
    logic            accept;
    logic            err;
    logic [AW-1:0]   widx;
    logic [31:0]     word;
    logic [31:0]     ld_data;
    logic [31:0]     wd_lanes;
    logic [3:0]      be;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign accept = req_valid && req_ready;
    assign widx   = req_addr[AW+1:2];
    assign word   = mem[widx];

    always_comb begin
        err = 1'b0;
        if (req_size == 2'd3)
            err = 1'b1;
        if (req_size == 2'd1 && req_addr[0])
            err = 1'b1;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
            err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))
            err = 1'b1;
    end

    always_comb begin
        case (req_addr[1:0])
            2'd0:    ld_byte = word[7:0];
            2'd1:    ld_byte = word[15:8];
            2'd2:    ld_byte = word[23:16];
            default: ld_byte = word[31:24];
        endcase
        ld_half = req_addr[1] ? word[31:16] : word[15:0];
        case (req_size)
            2'd0:    ld_data = req_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = req_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be       = 4'b0000;
        wd_lanes = req_wdata;
        case (req_size)
            2'd0: begin
                be       = 4'b0001 << req_addr[1:0];
                wd_lanes = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be       = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{req_wdata[15:0]}};
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[widx][8*i +: 8] <= wd_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt        <= 4'(LATENCY - 1);
                resp_err   <= err;
                resp_rdata <= (err || req_we) ? 32'h0 : ld_data;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: one instance at LATENCY=1 and one at LATENCY=4, with a
// scoreboard of expected {err, rdata} pushed at acceptance and popped at response.
module tb_dmem_hs;

    logic        clk;
    logic        reset;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    logic [32:0] sb [$];
    int          checks = 0;
    int          fails  = 0;

    dmem_hs #(.DEPTH(64), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_hs #(.DEPTH(64), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic drive(input int d, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
    endtask

    // Waits (from a negedge) for resp_valid; returns the number of negedges seen.
    task automatic wait_resp(input int d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid[d] && lat < 50);
    endtask

    task automatic xact(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic exp_e, input string nm);
        int n;
        int lat;
        logic [32:0] e;
        @(negedge clk);
        drive(d, we, size, uns, addr, wdata);
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready[d]);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        sb.push_back({exp_e, exp_d});
        checks++;
        if (req_ready[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: req_ready=%b required 0", nm, req_ready[d]);
        end
        wait_resp(d, lat);
        checks++;
        if (lat != lat_of(d) || resp_valid[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s latency: got %0d (valid=%b) required %0d", nm, lat, resp_valid[d], lat_of(d));
        end
        e = sb.pop_front();
        checks++;
        if ({resp_err[d], resp_rdata[d]} !== e) begin
            fails++;
            $display("FAIL %s data: err=%b rdata=%h required err=%b rdata=%h",
                     nm, resp_err[d], resp_rdata[d], e[32], e[31:0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b required 0/1",
                     nm, resp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d]: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word;
        xact(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_0x10");
        xact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_0x10");
        xact(0, 1'b1, 2'd2, 1'b0, 32'hFC, 32'h87654321, 32'h0, 1'b0, "sw_last");
        xact(0, 1'b0, 2'd2, 1'b1, 32'hFC, 32'h0, 32'h87654321, 1'b0, "lw_last");
    endtask

    task automatic test_extend;
        xact(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_0x13");
        xact(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h000000BE, 1'b0, "lbu_0x11");
        xact(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_0x12");
        xact(0, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_0x10");
        xact(0, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, "lb_0x10");
    endtask

    task automatic test_partial_store;
        xact(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, "sb_0x11");
        xact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_after_sb");
        xact(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0, "sh_0x12");
        xact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0, "lw_after_sh");
    endtask

    task automatic test_faults;
        xact(0, 1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1, "lh_misaligned");
        xact(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, "sw_0x20");
        xact(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_misaligned");
        xact(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, "lw_unchanged");
        xact(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "size3");
        xact(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "lw_range");
        xact(0, 1'b1, 2'd0, 1'b0, 32'h100, 32'h77, 32'h0, 1'b1, "sb_range");
    endtask

    task automatic test_stall;
        int lat;
        logic [32:0] e;
        xact(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, "l4_sw_0x10");
        @(negedge clk);
        resp_ready[1] = 1'b0;
        drive(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        sb.push_back({1'b0, 32'hCAFEF00D});
        drive(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        wait_resp(1, lat);
        checks++;
        if (lat != 4 || resp_valid[1] !== 1'b1) begin
            fails++;
            $display("FAIL stall latency: got %0d (valid=%b) required 4", lat, resp_valid[1]);
        end
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 ||
                {resp_err[1], resp_rdata[1]} !== e) begin
                fails++;
                $display("FAIL stall hold[%0d]: valid=%b ready=%b err=%b rdata=%h required 1/0/%b/%h",
                         i, resp_valid[1], req_ready[1], resp_err[1], resp_rdata[1], e[32], e[31:0]);
            end
            @(negedge clk);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            fails++;
            $display("FAIL stall release: ready=%b valid=%b required 1/0", req_ready[1], resp_valid[1]);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        sb.push_back({1'b0, 32'h000000CA});
        checks++;
        if (req_ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL held request accept: ready=%b required 0", req_ready[1]);
        end
        wait_resp(1, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 4 || {resp_err[1], resp_rdata[1]} !== e) begin
            fails++;
            $display("FAIL held request resp: lat=%0d err=%b rdata=%h required 4/%b/%h",
                     lat, resp_err[1], resp_rdata[1], e[32], e[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic abort_after_two(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input string nm);
        int seen;
        @(negedge clk);
        drive(1, we, 2'd2, 1'b0, addr, wdata);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            fails++;
            $display("FAIL %s reset: ready=%b valid=%b required 1/0", nm, req_ready[1], resp_valid[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid[1]) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL %s dropped: resp_valid high %0d cycles required 0", nm, seen);
        end
    endtask

    task automatic test_reset_mid;
        abort_after_two(1'b1, 32'h24, 32'hA5A5A5A5, "abort_sw");
        abort_after_two(1'b0, 32'h10, 32'h0, "abort_lw");
        xact(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0, "l4_lw_after_reset");
        xact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0, "l1_mem_kept");
    endtask

    initial begin
        test_reset;
        test_word;
        test_extend;
        test_partial_store;
        test_faults;
        test_stall;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
Handshaked, parametrised data memory for the pipelined RV32 core. It replaces the single-cycle byte/half/word store RAM with a valid/ready request/response port and a configurable read latency. It also performs load sign/zero extension internally and reports misaligned, illegal-size and out-of-range accesses. It sits behind the MEM stage, which stalls on req_ready/resp_valid.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, ≥4.
LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..8.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  access faulted; no side effect occurred

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM in IDLE, counter 0.
- Reset does not touch memory contents. Memory is zero at time 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Acceptance occurs when req_valid&&req_ready at a rising edge.
  - On acceptance: go to RESP if LATENCY==1, else go to WAIT with counter loaded to LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle. Move to RESP on the edge where the counter reaches 1→0.
  - RESP: resp_valid=1; resp_rdata and resp_err stay stable until a handshake.
  - On resp_valid&&resp_ready: go to IDLE and clear resp_valid. req_ready is high the next cycle.
- Timing: request accepted at edge t gives resp_valid high from edge t+LATENCY. Only one request is outstanding at a time. Minimum spacing between acceptances is LATENCY+1 cycles.
- Error check, evaluated at acceptance; err=1 if any of:
  - req_size==3
  - size 1 with addr[0]≠0
  - size 2 with addr[1:0]≠0
  - word index addr[31:2] ≥ DEPTH
- On error: no write, resp_rdata=0, resp_err=1.
- Store: commits at the acceptance edge.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: full word is written.
  - Untouched lanes are preserved.
  - resp_rdata=0.
- Load: the word is captured at the acceptance edge, then the selected lane is extended per req_unsigned.
  - Byte lane: addr[1:0].
  - Half lane: addr[1].
  - Word: returned as-is; req_unsigned is ignored.
- Inputs are ignored when req_ready=0. resp_ready is ignored when resp_valid=0.
- Reset mid-operation (WAIT or RESP): return to IDLE and drop any pending response. A store already committed at acceptance remains in memory.
- Lane order is little-endian: byte 0 = bits [7:0].

Test Plan:
1. LATENCY=1, resp_ready tied 1. Word store 0xDEADBEEF to 0x10, then word load 0x10 → resp_valid 1 cycle after each acceptance; load returns 0xDEADBEEF with err=0.
2. Memory word 0x10 = 0xDEADBEEF. Load byte signed at 0x13 → 0xFFFFFFDE. Load byte unsigned at 0x11 → 0x000000BE. Load half signed at 0x12 → 0xFFFFDEAD. Load half unsigned at 0x10 → 0x0000BEEF.
3. Byte store 0x55 to 0x11 over 0xDEADBEEF, then word load → 0xDEAD55EF. Half store 0x1234 to 0x12, then word load → 0x123455EF.
4. Fault cases:
   - Half load at 0x01 → err=1, rdata=0.
   - Word store at 0x22 → err=1 and word 0x20 unchanged.
   - size=3 → err=1.
   - Address 0x100 with DEPTH=64 → err=1.
5. LATENCY=4, resp_ready held low for 3 cycles after resp_valid:
   - resp_valid rises exactly 4 edges after acceptance.
   - rdata/err stay stable while stalled.
   - req_ready stays 0 until the cycle after the resp handshake.
   - A second req_valid held during the stall is accepted only then.
6. LATENCY=4: reset asserted 2 cycles after accepting a load → resp_valid never rises and req_ready=1 immediately. A store accepted before reset is visible on a subsequent load.
